// File: rtl/sp_ram_arb.sv
// Two-port round-robin arbiter in front of a single-port byte-lane RAM.
// Define SP_RAM_ARB_RDATA_REG_EN to add a response register stage (latency 2 instead of 1).
module sp_ram_arb #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 32768
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    p0_req_i,
    output logic                    p0_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
    input  logic                    p0_we_i,
    input  logic [DATA_WIDTH/8-1:0] p0_be_i,
    input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
    output logic                    p0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   p0_rdata_o,
    input  logic                    p1_req_i,
    output logic                    p1_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
    input  logic                    p1_we_i,
    input  logic [DATA_WIDTH/8-1:0] p1_be_i,
    input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
    output logic                    p1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   p1_rdata_o
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam int OFFS  = $clog2(LANES);
    localparam int DEPTH = NUM_WORDS / LANES;
    localparam int IDX_W = ADDR_WIDTH - OFFS;

    // Handshake: pn_gnt_o is combinational from pn_req_i and means the access happens at
    // this clock edge; exactly one pn_rvalid_o pulse follows each grant, for reads and writes.
    logic                  last_gnt;  // 1: port 1 was granted most recently
    logic                  gnt0, gnt1, any_gnt;
    logic [IDX_W-1:0]      idx;
    logic                  we;
    logic [LANES-1:0]      be;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  rv0_q, rv1_q, is_rd_q;
    logic                  rv0_out, rv1_out;
    logic [DATA_WIDTH-1:0] rd0_out, rd1_out;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (p0_req_i && (!p1_req_i || last_gnt)) begin
                gnt0 = 1'b1;
            end else if (p1_req_i) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign any_gnt = gnt0 | gnt1;
    assign idx     = gnt1 ? p1_addr_i[ADDR_WIDTH-1:OFFS] : p0_addr_i[ADDR_WIDTH-1:OFFS];
    assign we      = gnt1 ? p1_we_i    : p0_we_i;
    assign be      = gnt1 ? p1_be_i    : p0_be_i;
    assign wdata   = gnt1 ? p1_wdata_i : p0_wdata_i;

    if (OFFS > 0) begin : g_unused
        logic unused_addr_lsb;
        assign unused_addr_lsb = ^{p0_addr_i[OFFS-1:0], p1_addr_i[OFFS-1:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= 1'b1;
        end else if (gnt0) begin
            last_gnt <= 1'b0;
        end else if (gnt1) begin
            last_gnt <= 1'b1;
        end
    end

    // One independent RAM per byte lane; read-first, contents are never reset.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_byte;
        always_ff @(posedge clk) begin
            if (any_gnt) begin
                if (we && be[k]) begin
                    mem[idx] <= wdata[8*k +: 8];
                end
                rd_byte <= mem[idx];
            end
        end
        assign rd_word[8*k +: 8] = rd_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            is_rd_q <= 1'b0;
        end else begin
            rv0_q   <= gnt0;
            rv1_q   <= gnt1;
            is_rd_q <= any_gnt & ~we;
        end
    end

`ifdef SP_RAM_ARB_RDATA_REG_EN
    logic                  rv0_q2, rv1_q2;
    logic [DATA_WIDTH-1:0] rd0_q2, rd1_q2;

    always_ff @(posedge clk) begin
        if (rst) begin
            rv0_q2 <= 1'b0;
            rv1_q2 <= 1'b0;
            rd0_q2 <= '0;
            rd1_q2 <= '0;
        end else begin
            rv0_q2 <= rv0_q;
            rv1_q2 <= rv1_q;
            rd0_q2 <= (rv0_q && is_rd_q) ? rd_word : '0;
            rd1_q2 <= (rv1_q && is_rd_q) ? rd_word : '0;
        end
    end

    assign rv0_out = rv0_q2;
    assign rv1_out = rv1_q2;
    assign rd0_out = rd0_q2;
    assign rd1_out = rd1_q2;
`else
    assign rv0_out = rv0_q;
    assign rv1_out = rv1_q;
    assign rd0_out = (rv0_q && is_rd_q) ? rd_word : '0;
    assign rd1_out = (rv1_q && is_rd_q) ? rd_word : '0;
`endif

    // Responses are masked while rst is high, which also drops one pending from the prior cycle.
    assign p0_gnt_o    = gnt0;
    assign p1_gnt_o    = gnt1;
    assign p0_rvalid_o = rv0_out & ~rst;
    assign p1_rvalid_o = rv1_out & ~rst;
    assign p0_rdata_o  = rst ? '0 : rd0_out;
    assign p1_rdata_o  = rst ? '0 : rd1_out;

endmodule

// File: doc/sp_ram_arb.md
SP_RAM_ARB -- requirements
Module: sp_ram_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 15, byte-address width of each port.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width in bits, a multiple of 8.
REQ-003 SHALL have parameter NUM_WORDS, default 32768, capacity in bytes; depth = NUM_WORDS/(DATA_WIDTH/8) words.
REQ-004 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have, for each port n in {0,1}, pn_req_i  input  1  access request.
REQ-007 SHALL have pn_gnt_o  output  1  request accepted this cycle.
REQ-008 SHALL have pn_addr_i  input  ADDR_WIDTH  byte address.
REQ-009 SHALL have pn_we_i  input  1  1=write, 0=read.
REQ-010 SHALL have pn_be_i  input  DATA_WIDTH/8  byte enables, writes only.
REQ-011 SHALL have pn_wdata_i  input  DATA_WIDTH  write data.
REQ-012 SHALL have pn_rvalid_o  output  1  response for an earlier grant.
REQ-013 SHALL have pn_rdata_o  output  DATA_WIDTH  read data, qualified by pn_rvalid_o.

Function
REQ-014 SHALL store data as DATA_WIDTH/8 independent byte lanes of depth words, addressed by addr[ADDR_WIDTH-1:$clog2(DATA_WIDTH/8)]; low address bits ignored.
REQ-015 SHALL grant at most one port per cycle, combinationally from pn_req_i in the same cycle.
REQ-016 SHALL grant a sole requester immediately.
REQ-017 SHALL, when both ports request, grant the port not granted most recently (round-robin); the last-granted pointer updates only on a grant.
REQ-018 SHALL perform the granted access in the grant cycle: a write updates only lanes with pn_be_i[k]=1; a read captures the full word.
REQ-019 SHALL assert pn_rvalid_o for exactly one cycle, one cycle after each grant to port n, for reads and writes alike.
REQ-020 SHALL drive pn_rdata_o with the read word while pn_rvalid_o=1 after a read; drive 0 when pn_rvalid_o=0 or after a write.
REQ-021 SHALL return data written in cycle N to a read granted in cycle N+1 or later (no stale read); concurrent same-address conflicts cannot occur, as one port is granted per cycle.
REQ-022 SHALL sustain one access per cycle; a requester held off retains pn_req_i and its inputs until granted.
REQ-023 SHALL treat pn_be_i=0 on a write as a no-op write that still returns rvalid.
REQ-024 SHALL ignore pn_addr_i/we_i/be_i/wdata_i in cycles where pn_req_i=0 or pn_gnt_o=0.

Reset
REQ-025 SHALL, while rst=1, drive p0_gnt_o=p1_gnt_o=0, p0_rvalid_o=p1_rvalid_o=0, p0_rdata_o=p1_rdata_o=0, and suppress all writes.
REQ-026 SHALL set the last-granted pointer to port 1 on reset, so port 0 wins the first contended cycle.
REQ-027 SHALL, if rst asserts the cycle after a grant, drop the pending rvalid; memory contents are preserved across reset.

Configuration
REQ-028 SHALL, with macro SP_RAM_ARB_RDATA_REG_EN defined, add one output register stage: pn_rvalid_o/pn_rdata_o appear two cycles after the grant; throughput stays one access per cycle; the stage is cleared by rst.
REQ-029 SHALL, without SP_RAM_ARB_RDATA_REG_EN, have response latency of exactly one cycle per REQ-019.

Verification
REQ-030 Reset then p0 write addr 0x10, be=4'hF, wdata=32'hDEADBEEF; p0 read 0x10 next cycle -> p0_gnt_o both cycles, p0_rvalid_o one cycle after each, rdata 32'hDEADBEEF after the read.
REQ-031 Word 0x20 = 32'h11223344; p1 write be=4'b0101, wdata=32'hAABBCCDD; read -> 32'h11BB33DD.
REQ-032 Both ports request reads every cycle for 6 cycles after reset -> grants alternate p0,p1,p0,...; each port gets 3 rvalids.
REQ-033 p0 writes 0x40=32'h5 in cycle N, p1 reads 0x40 in cycle N+1 -> p1_rdata_o=32'h5.
REQ-034 Read granted, rst asserted next cycle -> no rvalid; after reset, the read returns the pre-reset contents.
REQ-035 With SP_RAM_ARB_RDATA_REG_EN, back-to-back p0 reads of 0x0, 0x4 -> rvalid at grant+2 for each, data in order.
